// File: rtl/ttt_spike_queue_if.sv
// ttt_spike_queue_if
//   Bundles the spike-queue data path and host handshake signals.
//   master : event source / host side (drives in_*, out_ack, clear_overflow)
//   slave  : the queue itself (drives out_*, level, overflow, drop_count)
//   in_valid, in_id     : spike event from the neuron core
//   out_valid, out_id   : head of queue presented to the host
//   out_ack             : host ack pin, asynchronous level
//   clear_overflow      : one-cycle clear of overflow / drop_count
//   level               : occupancy 0..DEPTH
//   overflow            : sticky "an event was dropped"
//   drop_count          : saturating count of dropped events
interface ttt_spike_queue_if #(
    parameter int ID_BITS = 4,
    parameter int DEPTH   = 8
);
    localparam int LW = $clog2(DEPTH) + 1;

    logic               in_valid;
    logic [ID_BITS-1:0] in_id;
    logic               out_valid;
    logic [ID_BITS-1:0] out_id;
    logic               out_ack;
    logic               clear_overflow;
    logic [LW-1:0]      level;
    logic               overflow;
    logic [7:0]         drop_count;

    modport master (
        output in_valid, in_id, out_ack, clear_overflow,
        input  out_valid, out_id, level, overflow, drop_count
    );

    modport slave (
        input  in_valid, in_id, out_ack, clear_overflow,
        output out_valid, out_id, level, overflow, drop_count
    );
endinterface

// File: rtl/ttt_spike_queue.sv
// ttt_spike_queue
//   Circular event queue between the neuron core (one spike ID per cycle at
//   most) and a slow host that pops the head via a valid/ack pin handshake.
//   Events arriving while full are dropped and counted rather than stalling
//   the core.
//   clk   : single clock, all state on rising edge
//   reset : synchronous, active-high, clears all state
//   q     : ttt_spike_queue_if.slave (event input, head output, ack, status)
module ttt_spike_queue #(
    parameter int ID_BITS = 4,
    parameter int DEPTH   = 8
) (
    input  logic              clk,
    input  logic              reset,
    ttt_spike_queue_if.slave  q
);
    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;

    logic [ID_BITS-1:0] storage [DEPTH];
    logic [AW-1:0]      wr_ptr, rd_ptr;
    logic [LW-1:0]      count;
    logic               ovf;
    logic [7:0]         drops;
    // s1/s2 synchronise the ack pin; s3 remembers the previous synced value
    logic               s1, s2, s3;

    logic pop_req, empty, full, do_pop, do_push, do_drop;

    assign pop_req = s2 & ~s3;
    assign empty   = (count == '0);
    assign full    = (count == LW'(DEPTH));
    assign do_pop  = pop_req & ~empty;
    // A pop on the same edge frees the slot, so a full queue still accepts.
    assign do_push = q.in_valid & (~full | do_pop);
    assign do_drop = q.in_valid & full & ~do_pop;

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            ovf    <= 1'b0;
            drops  <= 8'd0;
            // Synchroniser resets high: an ack already high at release must
            // not look like a rising edge.
            s1     <= 1'b1;
            s2     <= 1'b1;
            s3     <= 1'b1;
        end else begin
            s1 <= q.out_ack;
            s2 <= s1;
            s3 <= s2;

            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;

            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: ;
            endcase

            // Clear first, then record a drop from the same cycle on top.
            if (q.clear_overflow) begin
                ovf   <= do_drop;
                drops <= do_drop ? 8'd1 : 8'd0;
            end else if (do_drop) begin
                ovf <= 1'b1;
                if (drops != 8'hFF) drops <= drops + 8'd1;
            end
        end
    end

    // Storage has no reset; contents are only meaningful below count.
    always_ff @(posedge clk) begin
        if (!reset && do_push) storage[wr_ptr] <= q.in_id;
    end

    assign q.out_valid  = ~empty;
    assign q.out_id     = empty ? '0 : storage[rd_ptr];
    assign q.level      = count;
    assign q.overflow   = ovf;
    assign q.drop_count = drops;
endmodule
